// File: rtl/md5_round_engine.sv
// md5_round_engine
//   Iterative MD5 compression core: one 512-bit block against a 128-bit
//   chaining value, STEPS_PER_CLK of the 64 steps evaluated per clock.
//   Optional feature macro: MD5_TARGET_MATCH_EN (adds target/match ports).
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   block + chain_in acceptance handshake
//   block[511:0]        message, word j = block[32j+31:32j]
//   chain_in[127:0]     A=[31:0] B=[63:32] C=[95:64] D=[127:96]
//   out_valid/out_ready digest delivery handshake
//   digest[127:0]       updated chaining value, same layout as chain_in
//   busy                engine is in RUN or DONE
//   target, match       (MD5_TARGET_MATCH_EN) compare digest to a target
module md5_round_engine #(
    parameter int  STEPS_PER_CLK = 1,
    localparam int ITERS         = 64 / STEPS_PER_CLK
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block,
    input  logic [127:0] chain_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] digest,
`ifdef MD5_TARGET_MATCH_EN
    input  logic [127:0] target,
    output logic         match,
`endif
    output logic         busy
);

    if (!(STEPS_PER_CLK == 1 || STEPS_PER_CLK == 2 || STEPS_PER_CLK == 4 ||
          STEPS_PER_CLK == 8 || STEPS_PER_CLK == 16)) begin : g_bad_steps
        $error("md5_round_engine: STEPS_PER_CLK must be 1, 2, 4, 8 or 16");
    end

    // Step counter value at the start of the final RUN step cycle.
    localparam logic [5:0] LAST_STEP = 6'((ITERS - 1) * STEPS_PER_CLK);

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Per-round shift pattern repeats every four steps.
    function automatic logic [4:0] shift_amt(input logic [5:0] i);
        case ({i[5:4], i[1:0]})
            4'h0: shift_amt = 5'd7;   4'h1: shift_amt = 5'd12;
            4'h2: shift_amt = 5'd17;  4'h3: shift_amt = 5'd22;
            4'h4: shift_amt = 5'd5;   4'h5: shift_amt = 5'd9;
            4'h6: shift_amt = 5'd14;  4'h7: shift_amt = 5'd20;
            4'h8: shift_amt = 5'd4;   4'h9: shift_amt = 5'd11;
            4'ha: shift_amt = 5'd16;  4'hb: shift_amt = 5'd23;
            4'hc: shift_amt = 5'd6;   4'hd: shift_amt = 5'd10;
            4'he: shift_amt = 5'd15;  default: shift_amt = 5'd21;
        endcase
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        rotl = (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [511:0]  blk_q;
    logic [127:0]  chain_q;
    logic [31:0]   a_q, b_q, c_q, d_q;
    logic [5:0]    step_q;
    logic          fin_q;       // all 64 steps applied, digest add pending
    logic          accept;
    logic [31:0]   na, nb, nc, nd, f, t, tmp;
    logic [5:0]    idx;
    logic [3:0]    g;
    logic [127:0]  sum;
`ifdef MD5_TARGET_MATCH_EN
    logic [127:0]  target_q;
`endif

    // Held low through reset so no block can be offered against an engine
    // that is not running yet.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    assign sum       = {d_q + chain_q[127:96], c_q + chain_q[95:64],
                        b_q + chain_q[63:32],  a_q + chain_q[31:0]};

    // NOTE: every variable written here gets a default before the loop so no
    // path leaves a value held, which would infer a latch.
    always_comb begin
        na  = a_q;
        nb  = b_q;
        nc  = c_q;
        nd  = d_q;
        f   = '0;
        t   = '0;
        tmp = '0;
        idx = '0;
        g   = '0;
        for (int k = 0; k < STEPS_PER_CLK; k++) begin
            idx = step_q + 6'(k);
            case (idx[5:4])
                2'd0: begin f = (nb & nc) | (~nb & nd); g = idx[3:0];                end
                2'd1: begin f = (nb & nd) | (nc & ~nd); g = idx[3:0] * 4'd5 + 4'd1; end
                2'd2: begin f = nb ^ nc ^ nd;           g = idx[3:0] * 4'd3 + 4'd5; end
                default: begin f = nc ^ (nb | ~nd);     g = idx[3:0] * 4'd7;        end
            endcase
            t   = na + f + K_TAB[idx] + blk_q[{g, 5'd0} +: 32];
            tmp = nd;
            nd  = nc;
            nc  = nb;
            nb  = nb + rotl(t, shift_amt(idx));
            na  = tmp;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (fin_q)     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: the captured block is a plain register bank, not a RAM, so it is
    // cleared on reset like everything else and an aborted block leaves nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q    <= '0;
            chain_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            step_q   <= '0;
            fin_q    <= 1'b0;
            digest   <= '0;
`ifdef MD5_TARGET_MATCH_EN
            target_q <= '0;
            match    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    blk_q    <= block;
                    chain_q  <= chain_in;
                    a_q      <= chain_in[31:0];
                    b_q      <= chain_in[63:32];
                    c_q      <= chain_in[95:64];
                    d_q      <= chain_in[127:96];
                    step_q   <= '0;
                    fin_q    <= 1'b0;
`ifdef MD5_TARGET_MATCH_EN
                    target_q <= target;
`endif
                end
                RUN: if (!fin_q) begin
                    a_q    <= na;
                    b_q    <= nb;
                    c_q    <= nc;
                    d_q    <= nd;
                    step_q <= step_q + 6'(STEPS_PER_CLK);
                    fin_q  <= (step_q == LAST_STEP);
                end else begin
                    digest <= sum;
                    fin_q  <= 1'b0;
`ifdef MD5_TARGET_MATCH_EN
                    match  <= (sum == target_q);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/md5_round_engine.md
# md5_round_engine

Iterative, parametrised MD5 compression core that processes one 512-bit block against a 128-bit chaining value and returns the updated 128-bit digest. It implements all 64 RFC 1321 steps with a configurable number of steps unrolled per clock. Valid/ready handshakes sit on both sides, so multiple engines can be tiled behind a candidate generator in the hash-breaker datapath.

## Interface
Parameters:
- STEPS_PER_CLK, default 1: MD5 steps evaluated combinationally per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- ITERS, derived as 64/STEPS_PER_CLK: number of RUN cycles per block.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  block and chain inputs are valid.
- in_ready  out  1  engine can accept a block.
- block  in  512  message; word j = block[32j+31:32j], each word little-endian.
- chain_in  in  128  A=[31:0], B=[63:32], C=[95:64], D=[127:96].
- out_valid  out  1  digest is valid.
- out_ready  in  1  consumer accepts the digest.
- digest  out  128  same layout as chain_in.
- busy  out  1  high in RUN or DONE.
- match  out  1  only present with MD5_TARGET_MATCH_EN.
- target  in  128  only present with MD5_TARGET_MATCH_EN.

## Operation
- FSM states and transitions:
  - IDLE -> RUN on in_valid&&in_ready.
  - RUN -> DONE after ITERS cycles.
  - DONE -> IDLE on out_valid&&out_ready.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state!=IDLE).
- On accept, the engine captures:
  - block, chain_in (and target when the macro is set);
  - working registers a,b,c,d = chain_in words;
  - step counter = 0.
- Step i (0..63):
  - Round functions, all 32-bit:
    - i<16: F=(b&c)|(~b&d), g=i.
    - i<32: F=(b&d)|(c&~d), g=(5i+1) mod 16.
    - i<48: F=b^c^d, g=(3i+5) mod 16.
    - else: F=c^(b|~d), g=7i mod 16.
  - t = a+F+K[i]+M[g], mod 2^32.
  - Update: a<=d, d<=c, c<=b, b<=b+rotl32(t,s[i]).
  - K[i] = floor(abs(sin(i+1))*2^32). s[i] is the RFC 1321 shift table.
  - rotl is a true rotate: (t<<s)|(t>>(32-s)).
- Each RUN cycle chains STEPS_PER_CLK steps. The step counter advances by STEPS_PER_CLK per cycle and is 6 bits wide.
- The last RUN cycle registers the final digest: each word of digest = working word + corresponding chain_in word, mod 2^32.
- In DONE, digest and match are held stable until the handshake completes. Inputs are ignored outside IDLE.
- Reset values: in_ready=0 while rst_n=0, then 1 in IDLE. out_valid=0, busy=0, digest=0, match=0. Internal registers are 0 and the state is IDLE.
- Reset asserted mid-RUN or mid-DONE aborts the block. No output is produced for it and nothing is retained.

## Timing
- Accept edge at cycle 0; first step executes at edge 1.
- out_valid rises ITERS+1 edges after the accept edge:
  - STEPS_PER_CLK=1: 65 cycles.
  - STEPS_PER_CLK=4: 17 cycles.
- Minimum block-to-block interval is ITERS+2 cycles, with out_ready held high.
- out_ready low stalls indefinitely in DONE; in_ready stays 0 throughout.
- out_ready asserted before out_valid has no effect.
- in_ready returns 1 on the edge after the output handshake. No same-cycle output/input overlap.

## Configuration
- MD5_TARGET_MATCH_EN defined:
  - Adds the target port, captured at accept.
  - Adds the match port, registered alongside digest. match=1 iff digest==target, and is valid only while out_valid=1.
- MD5_TARGET_MATCH_EN undefined: both ports are absent and no comparator is built. All other behaviour is identical.

## Test plan
- Empty-string MD5:
  - Stimulus: block word0=0x00000080, all other words 0; chain_in = {0x10325476,0x98badcfe,0xefcdab89,0x67452301}.
  - Response: digest A=0xd98c1dd4, B=0x04b2008f, C=0x980980e9, D=0x7e42f8ec, with out_valid at cycle 65 (STEPS_PER_CLK=1).
- "abc":
  - Stimulus: word0=0x80636261, word14=0x00000018, rest 0, standard chain.
  - Response: A=0x98500190, B=0xb04fd23c, C=0x7d3f96d6, D=0x727fe128.
  - Repeat for STEPS_PER_CLK = 2, 4, 8 and 16; latencies must be 33, 17, 9 and 5.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Response: digest stable, in_ready=0, busy=1; one accepted output on release; in_ready=1 on the next edge.
- Reset mid-RUN:
  - Stimulus: drop rst_n at step 30.
  - Response: all outputs 0 immediately; after release, a fresh "abc" block yields the correct digest.
- With MD5_TARGET_MATCH_EN:
  - target = "abc" digest gives match=1.
  - target with bit 0 flipped gives match=0.
  - Without the macro, the design elaborates with no match or target ports.
